// File: rtl/dequant_pkg.sv
// Shared constants for the inverse quantizer: widths, subband codes and the
// per-subband reconstruction steps (inverse of the forward gain table).
package dequant_pkg;
    localparam int Q_W = 17;
    localparam int D_W = 16;
    localparam int P_W = 34;

    localparam logic [15:0] S_LL5    = 16'd3856;
    localparam logic [15:0] S_LHHL5  = 16'd3816;
    localparam logic [15:0] S_HH5    = 16'd3768;
    localparam logic [15:0] S_LHHL4  = 16'd7672;
    localparam logic [15:0] S_HH4    = 16'd7616;
    localparam logic [15:0] S_LHHL3  = 16'd15664;
    localparam logic [15:0] S_HH3    = 16'd15752;
    localparam logic [15:0] S_LHHL2  = 16'd32816;
    localparam logic [15:0] S_HH2    = 16'd33873;
    localparam logic [15:0] S_LHHL1  = 16'd64808;
    localparam logic [15:0] S_HH1    = 16'd62987;

    typedef enum logic [3:0] {
        SB_LL5 = 4'd0, SB_HL5, SB_LH5, SB_HH5,
        SB_HL4, SB_LH4, SB_HH4,
        SB_HL3, SB_LH3, SB_HH3,
        SB_HL2, SB_LH2, SB_HH2,
        SB_HL1, SB_LH1, SB_HH1
    } subband_e;

    function automatic logic [15:0] step_of(input subband_e sb);
        case (sb)
            SB_LL5:          return S_LL5;
            SB_HL5, SB_LH5:  return S_LHHL5;
            SB_HH5:          return S_HH5;
            SB_HL4, SB_LH4:  return S_LHHL4;
            SB_HH4:          return S_HH4;
            SB_HL3, SB_LH3:  return S_LHHL3;
            SB_HH3:          return S_HH3;
            SB_HL2, SB_LH2:  return S_LHHL2;
            SB_HH2:          return S_HH2;
            SB_HL1, SB_LH1:  return S_LHHL1;
            default:         return S_HH1;
        endcase
    endfunction
endpackage

// File: rtl/dequant_lane.sv
// One lane of the inverse quantizer: S1 registers the product (or the raw
// index on bypass), S2 registers the rounded, saturated 16-bit coefficient.
module dequant_lane
    import dequant_pkg::*;
(
    input  logic           clk_qk,
    input  logic           rst_syn,
    input  logic           en_i,
    input  logic [Q_W-1:0] q_i,
    input  logic           byp_i,
    input  logic [15:0]    step_i,
    output logic [D_W-1:0] dq_o,
    output logic           sat_o
);
    localparam logic signed [P_W-1:0] RND_HALF = P_W'(32768);
    localparam logic signed [P_W-1:0] SAT_MAX  = P_W'(32767);
    localparam logic signed [P_W-1:0] SAT_MIN  = P_W'(-32768);

    logic signed [P_W-1:0] qx, sx, p_d, p_q, r;
    logic                  byp_q;
    logic [D_W-1:0]        dq_d, dq_q;

    always_comb begin
        qx  = P_W'($signed(q_i));
        sx  = P_W'({1'b0, step_i});
        p_d = byp_i ? qx : qx * sx;
    end

    // Bypass values skip the rounding shift but share the saturator.
    always_comb begin
        r = p_q;
        if (!byp_q) r = (p_q + RND_HALF) >>> 16;
        sat_o = 1'b0;
        dq_d  = r[D_W-1:0];
        if (r > SAT_MAX) begin
            dq_d  = 16'h7FFF;
            sat_o = 1'b1;
        end else if (r < SAT_MIN) begin
            dq_d  = 16'h8000;
            sat_o = 1'b1;
        end
    end

    always_ff @(posedge clk_qk) begin
        if (rst_syn) begin
            p_q   <= '0;
            byp_q <= 1'b0;
            dq_q  <= '0;
        end else if (en_i) begin
            p_q   <= p_d;
            byp_q <= byp_i;
            dq_q  <= dq_d;
        end
    end

    assign dq_o = dq_q;
endmodule

// File: rtl/dequant_circuit.sv
// Inverse scalar quantizer top: handshake, subband decode per DWT level and
// the saturating saturation-event counter around two lane instances.
module dequant_circuit
    import dequant_pkg::*;
(
    input  logic        clk_qk,
    input  logic        rst_syn,
    input  logic [16:0] q_l,
    input  logic [16:0] q_h,
    input  logic [2:0]  level,
    input  logic        ce0_ctrl,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [15:0] dq_l,
    output logic [15:0] dq_h,
    output logic        out_vld,
    input  logic        out_rdy,
    input  logic        sat_clr,
    output logic [15:0] sat_cnt
);
    localparam int STAGES = 2;

    logic [STAGES:1] vld_pipe_q;
    logic            en, split, byp_l, byp_h, sat_l, sat_h;
    subband_e        sb_l, sb_h;
    logic [1:0]      sat_inc;
    logic [16:0]     cnt_sum;
    logic [15:0]     sat_cnt_d, sat_cnt_q;

    assign en     = out_rdy | ~vld_pipe_q[STAGES];
    assign in_rdy = en;

    // Levels 0..3 alternate which ce0 value carries the split (LH-only) row.
    always_comb begin
        sb_l  = SB_LL5;
        sb_h  = SB_LL5;
        byp_l = 1'b1;
        byp_h = 1'b1;
        split = ce0_ctrl ^ level[0];
        case (level)
            3'd0: begin byp_l = split; byp_h = 1'b0; sb_l = SB_HL1; sb_h = split ? SB_LH1 : SB_HH1; end
            3'd1: begin byp_l = split; byp_h = 1'b0; sb_l = SB_HL2; sb_h = split ? SB_LH2 : SB_HH2; end
            3'd2: begin byp_l = split; byp_h = 1'b0; sb_l = SB_HL3; sb_h = split ? SB_LH3 : SB_HH3; end
            3'd3: begin byp_l = split; byp_h = 1'b0; sb_l = SB_HL4; sb_h = split ? SB_LH4 : SB_HH4; end
            3'd4: begin
                byp_l = 1'b0;
                byp_h = 1'b0;
                sb_l  = ce0_ctrl ? SB_LL5 : SB_HL5;
                sb_h  = ce0_ctrl ? SB_LH5 : SB_HH5;
            end
            default: ;
        endcase
    end

    dequant_lane u_lane_l (
        .clk_qk(clk_qk), .rst_syn(rst_syn), .en_i(en),
        .q_i(q_l), .byp_i(byp_l), .step_i(step_of(sb_l)),
        .dq_o(dq_l), .sat_o(sat_l)
    );

    dequant_lane u_lane_h (
        .clk_qk(clk_qk), .rst_syn(rst_syn), .en_i(en),
        .q_i(q_h), .byp_i(byp_h), .step_i(step_of(sb_h)),
        .dq_o(dq_h), .sat_o(sat_h)
    );

    // Count once, when a valid beat moves from S1 into S2.
    always_comb begin
        sat_inc   = (en && vld_pipe_q[1]) ? ({1'b0, sat_l} + {1'b0, sat_h}) : 2'd0;
        cnt_sum   = {1'b0, sat_cnt_q} + {15'd0, sat_inc};
        sat_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        if (sat_clr) sat_cnt_d = '0;
    end

    always_ff @(posedge clk_qk) begin
        if (rst_syn) begin
            vld_pipe_q <= '0;
            sat_cnt_q  <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
            if (en) vld_pipe_q <= {vld_pipe_q[1], in_vld};
        end
    end

    assign out_vld = vld_pipe_q[STAGES];
    assign sat_cnt = sat_cnt_q;
endmodule
